// File: rtl/dot_product_sequencer.sv
// Sequencer around an 8-bit sequential Booth multiplier that
// accumulates signed products into a saturating dot product.
module dot_product_sequencer #(
    parameter int ACC_W = 24,
    parameter int LEN_W = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [7:0]              in_a,
    input  logic [7:0]              in_b,
    input  logic                    in_last,
    output logic [7:0]              mul_mc,
    output logic [7:0]              mul_mp,
    output logic                    mul_load,
    output logic                    mul_start,
    input  logic [15:0]             mul_prod,
    input  logic                    mul_done,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [ACC_W-1:0] out_acc,
    output logic                    out_sat,
    output logic [LEN_W-1:0]        out_count
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN,
        CHECK,
        OUT
    } state_t;

    localparam logic signed [ACC_W-1:0] ACC_MAX =
        {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN =
        {1'b1, {(ACC_W-1){1'b0}}};

    state_t                  state;
    state_t                  state_next;
    logic [2:0]              step;
    logic                    last_q;
    logic signed [ACC_W:0]   acc_sum;
    logic signed [ACC_W-1:0] acc_nxt;
    logic                    ovf_pos;
    logic                    ovf_neg;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == OUT);

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (in_valid) state_next = LOAD;
            LOAD:    state_next = RUN;
            RUN:     if (step == 3'd7) state_next = CHECK;
            CHECK:   if (mul_done) state_next = last_q ? OUT : IDLE;
            OUT:     if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Top two bits of the widened sum disagree only on overflow
    always_comb begin
        acc_sum = {out_acc[ACC_W-1], out_acc}
                + {{(ACC_W+1-16){mul_prod[15]}}, mul_prod};
        ovf_pos = (acc_sum[ACC_W:ACC_W-1] == 2'b01);
        ovf_neg = (acc_sum[ACC_W:ACC_W-1] == 2'b10);
        acc_nxt = acc_sum[ACC_W-1:0];
        unique case (1'b1)
            ovf_pos: acc_nxt = ACC_MAX;
            ovf_neg: acc_nxt = ACC_MIN;
            default: acc_nxt = acc_sum[ACC_W-1:0];
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            step      <= 3'd0;
            last_q    <= 1'b0;
            mul_mc    <= 8'd0;
            mul_mp    <= 8'd0;
            mul_load  <= 1'b0;
            mul_start <= 1'b0;
            out_acc   <= '0;
            out_sat   <= 1'b0;
            out_count <= '0;
        end else begin
            state     <= state_next;
            mul_load  <= (state_next == LOAD);
            mul_start <= (state_next == RUN);
            if (state == IDLE && in_valid) begin
                mul_mc <= in_a;
                mul_mp <= in_b;
                last_q <= in_last;
            end
            if (state == LOAD)
                step <= 3'd0;
            else if (state == RUN)
                step <= step + 3'd1;
            if (state == CHECK && mul_done) begin
                out_acc   <= acc_nxt;
                out_sat   <= out_sat | ovf_pos | ovf_neg;
                out_count <= out_count + LEN_W'(1);
            end else if (state == OUT && out_ready) begin
                out_acc   <= '0;
                out_sat   <= 1'b0;
                out_count <= '0;
            end
        end
    end

endmodule
